// File: rtl/jt51_fir_pkg.sv
// ============================================================================
// jt51_fir_pkg
// Shared types and arithmetic helpers for the jt51 FIR sequencer.
// Optional: JT51_FIR_SAT_EN selects saturating narrowing.
// Revision: 1.0
// ============================================================================
`default_nettype none

package jt51_fir_pkg;

  typedef enum logic [2:0] {
    ST_CLR   = 3'd0,
    ST_IDLE  = 3'd1,
    ST_WRITE = 3'd2,
    ST_MAC   = 3'd3,
    ST_DRAIN = 3'd4,
    ST_OUT   = 3'd5
  } state_t;

  // Headroom of addr_width bits covers the sum of up to 2**addr_width products.
  function automatic int acc_width(input int dw, input int cw, input int aw);
    return dw + cw + aw;
  endfunction

  // Narrows a sign-extended value to dw bits (result sign-extended to 64 bits).
  function automatic logic signed [63:0] fir_narrow(input logic signed [63:0] val,
                                                    input int dw);
`ifdef JT51_FIR_SAT_EN
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (dw - 1));
    if (val > hi) return hi;
    if (val < lo) return lo;
    return val;
`else
    return (val <<< (64 - dw)) >>> (64 - dw);
`endif
  endfunction

endpackage

`default_nettype wire

// File: rtl/jt51_fir_seq_if.sv
// ============================================================================
// jt51_fir_seq_if
// Sample streams plus sample-RAM / coefficient-ROM buses of one FIR stage.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface jt51_fir_seq_if #(
  parameter int DATA_WIDTH = 16,
  parameter int COEF_WIDTH = 12,
  parameter int ADDR_WIDTH = 7
);
  logic [DATA_WIDTH-1:0] din;
  logic                  din_valid;
  logic                  din_ready;
  logic [DATA_WIDTH-1:0] dout;
  logic                  dout_valid;
  logic                  dout_ready;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_din;
  logic                  ram_we;
  logic [DATA_WIDTH-1:0] ram_q;
  logic [ADDR_WIDTH-1:0] coef_addr;
  logic [COEF_WIDTH-1:0] coef_q;

  // Sequencer view: drives both memory buses and the handshakes it owns.
  modport master (
    input  din, din_valid, dout_ready, ram_q, coef_q,
    output din_ready, dout, dout_valid, ram_addr, ram_din, ram_we, coef_addr
  );

  // Environment view: producer, consumer, RAM and ROM.
  modport slave (
    output din, din_valid, dout_ready, ram_q, coef_q,
    input  din_ready, dout, dout_valid, ram_addr, ram_din, ram_we, coef_addr
  );
endinterface

`default_nettype wire

// File: rtl/jt51_fir_mac.sv
// ============================================================================
// jt51_fir_mac
// Signed multiply-accumulate, final shift and narrowing to the output register.
// Revision: 1.0
// ============================================================================
`default_nettype none

module jt51_fir_mac
  import jt51_fir_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int COEF_WIDTH = 12,
  parameter int ADDR_WIDTH = 7
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clr,
  input  logic                         en,
  input  logic                         load,
  input  logic signed [DATA_WIDTH-1:0] sample,
  input  logic signed [COEF_WIDTH-1:0] coef,
  output logic        [DATA_WIDTH-1:0] dout
);

  localparam int c_acc_w  = acc_width(DATA_WIDTH, COEF_WIDTH, ADDR_WIDTH);
  localparam int c_prod_w = DATA_WIDTH + COEF_WIDTH;

  logic signed [c_prod_w-1:0] w_prod;
  logic signed [c_acc_w-1:0]  w_acc_next;
  logic signed [c_acc_w-1:0]  w_shift;
  logic        [DATA_WIDTH-1:0] w_dout;
  logic signed [c_acc_w-1:0]  r_acc;
  logic        [DATA_WIDTH-1:0] r_dout;

  // load coincides with the final enable, so the output sees the complete sum.
  always_comb begin
    w_prod     = sample * coef;
    w_acc_next = en ? (r_acc + c_acc_w'(w_prod)) : r_acc;
    w_shift    = w_acc_next >>> (COEF_WIDTH - 1);
    w_dout     = DATA_WIDTH'(fir_narrow(64'(w_shift), DATA_WIDTH));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc  <= '0;
      r_dout <= '0;
    end else begin
      if (clr) begin
        r_acc <= '0;
      end else begin
        r_acc <= w_acc_next;
      end
      if (load) begin
        r_dout <= w_dout;
      end
    end
  end

  assign dout = r_dout;

endmodule

`default_nettype wire

// File: rtl/jt51_fir_seq.sv
// ============================================================================
// jt51_fir_seq
// FIR stage sequencer: circular sample history in RAM, tap walk, MAC, output.
// Optional: JT51_FIR_SAT_EN (saturating output instead of wrap-around).
// Revision: 1.0
// ============================================================================
`default_nettype none

module jt51_fir_seq
  import jt51_fir_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int COEF_WIDTH = 12,
  parameter int ADDR_WIDTH = 7,
  parameter int TAPS       = 96
) (
  input  logic           clk,
  input  logic           rst,
  jt51_fir_seq_if.master bus
);

  localparam logic [ADDR_WIDTH-1:0] c_addr_max = {ADDR_WIDTH{1'b1}};
  localparam logic [ADDR_WIDTH-1:0] c_addr_one = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] c_last_k   = ADDR_WIDTH'(TAPS - 1);

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_clr_cnt;
  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_k;
  logic [DATA_WIDTH-1:0] r_sample;
  logic                  r_mac_d;
  logic                  r_dout_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_CLR;
      r_clr_cnt    <= '0;
      r_wr_ptr     <= '0;
      r_k          <= '0;
      r_sample     <= '0;
      r_mac_d      <= 1'b0;
      r_dout_valid <= 1'b0;
    end else begin
      // RAM/ROM data for a MAC address arrives one cycle later.
      r_mac_d <= (r_state == ST_MAC);
      case (r_state)
        ST_CLR: begin
          r_clr_cnt <= r_clr_cnt + c_addr_one;
          if (r_clr_cnt == c_addr_max) begin
            r_state <= ST_IDLE;
          end
        end
        ST_IDLE: begin
          if (bus.din_valid) begin
            r_sample <= bus.din;
            r_state  <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          r_k     <= '0;
          r_state <= ST_MAC;
        end
        ST_MAC: begin
          if (r_k == c_last_k) begin
            r_state <= ST_DRAIN;
          end else begin
            r_k <= r_k + c_addr_one;
          end
        end
        ST_DRAIN: begin
          r_dout_valid <= 1'b1;
          r_state      <= ST_OUT;
        end
        ST_OUT: begin
          if (bus.dout_ready) begin
            r_dout_valid <= 1'b0;
            r_wr_ptr     <= r_wr_ptr + c_addr_one;
            r_state      <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_CLR;
        end
      endcase
    end
  end

  always_comb begin
    bus.ram_we    = 1'b0;
    bus.ram_din   = '0;
    bus.ram_addr  = '0;
    bus.coef_addr = '0;
    bus.din_ready = 1'b0;
    case (r_state)
      ST_CLR: begin
        bus.ram_we   = 1'b1;
        bus.ram_addr = r_clr_cnt;
      end
      ST_IDLE: begin
        bus.din_ready = 1'b1;
      end
      ST_WRITE: begin
        bus.ram_we   = 1'b1;
        bus.ram_addr = r_wr_ptr;
        bus.ram_din  = r_sample;
      end
      ST_MAC: begin
        // Walks backwards from the newest sample; wraps mod 2**ADDR_WIDTH.
        bus.ram_addr  = r_wr_ptr - r_k;
        bus.coef_addr = r_k;
      end
      default: begin
      end
    endcase
  end

  assign bus.dout_valid = r_dout_valid;

  jt51_fir_mac #(
    .DATA_WIDTH (DATA_WIDTH),
    .COEF_WIDTH (COEF_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mac (
    .clk    (clk),
    .rst    (rst),
    .clr    (r_state == ST_WRITE),
    .en     (r_mac_d),
    .load   (r_state == ST_DRAIN),
    .sample (bus.ram_q),
    .coef   (bus.coef_q),
    .dout   (bus.dout)
  );

endmodule

`default_nettype wire

// File: doc/jt51_fir_seq.md
# jt51_fir_seq

Sequencer for one FIR filter stage built around a single-port sample RAM with a registered read address and an external coefficient ROM. Accepts one input sample at a time over a valid/ready handshake and writes it into a circular history buffer in the RAM. Then walks all taps, multiply-accumulating history × coefficient, and presents the filtered sample on a valid/ready output. Sits between the jt51 audio generator and the sample-rate/output stage, one instance per FIR stage.

## Interface
- data_width, 16: sample width, signed two's complement
- coef_width, 12: coefficient width, signed, Q1.(coef_width-1)
- addr_width, 7: sample RAM and coefficient ROM address width
- taps, 96: filter length, 1 ≤ taps ≤ 2**addr_width
---
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- din  in  data_width  input sample
- din_valid  in  1  din is valid
- din_ready  out  1  block accepts din this cycle
- dout  out  data_width  filtered sample
- dout_valid  out  1  dout is valid
- dout_ready  in  1  consumer accepts dout this cycle
- ram_addr  out  addr_width  sample RAM address
- ram_din  out  data_width  sample RAM write data
- ram_we  out  1  sample RAM write enable
- ram_q  in  data_width  sample RAM read data, valid the cycle after ram_addr
- coef_addr  out  addr_width  coefficient ROM address
- coef_q  in  coef_width  coefficient, valid the cycle after coef_addr

## Operation
- States: CLR, IDLE, WRITE, MAC, DRAIN, OUT. Reset forces CLR.
- CLR: ram_we=1, ram_din=0, ram_addr=clr_cnt, from 0 to 2**addr_width-1, one address per cycle. After the last address the block goes to IDLE.
- IDLE: din_ready=1. On din_valid, the block captures din and goes to WRITE. din_ready is 0 in every other state.
- WRITE: ram_we=1, ram_addr=wr_ptr, ram_din=captured sample. acc is cleared. Next state is MAC with k=0.
- MAC: ram_addr=(wr_ptr−k) mod 2**addr_width and coef_addr=k, for k=0..taps−1, one per cycle.
  - Each cycle after an address was issued: acc += ram_q × coef_q, signed.
  - After k=taps−1 the block goes to DRAIN.
- DRAIN: the last product is accumulated. Next state is OUT.
- OUT: dout_valid=1 and dout is held stable. When dout_ready=1, wr_ptr increments (wraps mod 2**addr_width) and the block goes to IDLE.
- Arithmetic:
  - acc width is data_width+coef_width+addr_width.
  - Result is acc arithmetically shifted right by (coef_width−1), i.e. floor.
  - The result is narrowed to data_width according to the Configuration section.
- ram_we=0 outside CLR and WRITE. Addresses are don't-care in IDLE, DRAIN and OUT but are driven to 0.
- Reset at any point, including mid-MAC or mid-OUT, takes effect at the next edge:
  - state CLR, wr_ptr=0, clr_cnt=0, acc=0
  - dout=0, dout_valid=0, din_ready=0
  - a pending output is discarded

## Timing
- Reset values, in the cycle after rst is sampled high: dout=0, dout_valid=0, din_ready=0, ram_we=1, ram_addr=0, ram_din=0, coef_addr=0.
- din_ready first rises 2**addr_width cycles after reset is released.
- Accept in cycle 0: WRITE in cycle 1, MAC in cycles 2..taps+1, DRAIN in cycle taps+2, dout_valid=1 from cycle taps+3.
- Minimum sample period is taps+4 cycles (IDLE, WRITE, MAC×taps, DRAIN, OUT).
- The write in WRITE commits before the first MAC read of the same address, so the newest sample is always read back.
- Control outputs are combinational from state and counters. dout and dout_valid are registered.

## Configuration
- JT51_FIR_SAT_EN defined: the shifted result saturates to [−2**(data_width−1), 2**(data_width−1)−1].
- JT51_FIR_SAT_EN undefined: the low data_width bits are taken, so overflow wraps.

## Structure
- The shared package jt51_fir_pkg holds:
  - the state enum
  - the accumulator-width constant function
  - the saturate/truncate function
- Sub-module jt51_fir_mac holds the signed multiplier, the accumulator with its clear and enable, and the final shift and narrowing.
- jt51_fir_seq holds the FSM, the counters and the RAM/ROM addressing.

## Test plan
Bench configuration: addr_width=3, taps=4, coef ROM = {1024, 512, 256, 0} unless stated otherwise.
- Reset release:
  - ram_we=1 with ram_din=0 at addresses 0..7 over 8 cycles, then din_ready=1.
  - dout_valid stays 0 throughout.
- Impulse: inputs 1000,0,0,0,0 → outputs 500,250,125,0,0. Each dout_valid rises exactly taps+3=7 cycles after acceptance.
- Sign: input −1000 followed by zeros → outputs −500,−250,−125,0.
- Wrap-around:
  - Feed a ramp 1..12 with coef {2047,0,0,0} (≈0.999).
  - Outputs track the input with floor rounding (n×2047>>11, i.e. 0,1,2,…,11).
  - Reads at wr_ptr 0 access addresses 0,7,6,5.
- Overflow:
  - Coef all 2047 and input 32767 repeated. The fourth output is 32767 with JT51_FIR_SAT_EN and −68 without it.
  - A matching negative case with SAT_EN saturates to −32768.
- Backpressure and mid-operation reset:
  - Hold dout_ready=0 for 20 cycles: dout stays stable and din_ready=0.
  - Assert rst during MAC: dout_valid=0 and the block re-enters CLR next cycle.
  - After the clear completes, the impulse test passes again from wr_ptr=0.
